// File: rtl/stream_fifo_pkg.sv
// Shared widths and defaults for the stream FIFO: pointer/count types derived from DEPTH.
package stream_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [DEFAULT_AW:0] ptr_t;
  typedef logic [DEFAULT_AW:0] cnt_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// 1W1R storage array: synchronous write, registered read output updated only on read enable.
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO feeding the ring buffer, with end-of-stream tracking and a DONE indication.
// Build option STREAM_FIFO_ERR_EN adds sticky OVERFLOW/UNDERFLOW outputs.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   CLR,
  input  logic [WIDTH-1:0]       WRDATA,
  input  logic                   WREN,
  input  logic                   WRLAST,
  output logic                   WRFULL,
  output logic [$clog2(DEPTH):0] WRCOUNT,
  input  logic                   RDEN,
  output logic [WIDTH-1:0]       RDDATA,
  output logic                   RDEMPTY,
  output logic                   DONE
`ifdef STREAM_FIFO_ERR_EN
  ,
  output logic                   OVERFLOW,
  output logic                   UNDERFLOW
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] r_wptr, r_rptr;
  logic          r_last_seen, r_rd_pend;
  logic [PW-1:0] w_count;
  logic          w_full, w_empty, w_wr, w_rd;

  // Strobe semantics: a write is taken on any edge where WREN=1 and WRFULL=0; a read is
  // taken where RDEN=1 and RDEMPTY=0, its word appearing on RDDATA after that edge.
  // Both flags are judged on the pre-edge state and CLR overrides both strobes.
  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_wr    = WREN & ~w_full & ~CLR;
  assign w_rd    = RDEN & ~w_empty & ~CLR;

  stream_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk     (CLK),
    .rst_n   (RESETn),
    .i_we    (w_wr),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (WRDATA),
    .i_re    (w_rd),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (RDDATA)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_seen <= 1'b0;
      r_rd_pend   <= 1'b0;
    end else if (CLR) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_last_seen <= 1'b0;
      r_rd_pend   <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && WRLAST) r_last_seen <= 1'b1;
      r_rd_pend <= w_rd;
    end
  end

  assign WRFULL  = w_full;
  assign WRCOUNT = w_count;
  assign RDEMPTY = w_empty;
  // Hold off DONE while the final word is still travelling to RDDATA.
  assign DONE    = r_last_seen & w_empty & ~r_rd_pend;

`ifdef STREAM_FIFO_ERR_EN
  logic r_overflow, r_underflow;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (CLR) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (WREN && w_full)  r_overflow  <= 1'b1;
      if (RDEN && w_empty) r_underflow <= 1'b1;
    end
  end

  assign OVERFLOW  = r_overflow;
  assign UNDERFLOW = r_underflow;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: directed vector table, fill/drain, wrap, async reset and random traffic.
module tb_stream_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic             CLK, RESETn, CLR, WREN, WRLAST, RDEN;
  logic [WIDTH-1:0] WRDATA, RDDATA;
  logic             WRFULL, RDEMPTY, DONE;
  logic [4:0]       WRCOUNT;
`ifdef STREAM_FIFO_ERR_EN
  logic             OVERFLOW, UNDERFLOW;
`endif

  stream_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .CLR     (CLR),
    .WRDATA  (WRDATA),
    .WREN    (WREN),
    .WRLAST  (WRLAST),
    .WRFULL  (WRFULL),
    .WRCOUNT (WRCOUNT),
    .RDEN    (RDEN),
    .RDDATA  (RDDATA),
    .RDEMPTY (RDEMPTY),
    .DONE    (DONE)
`ifdef STREAM_FIFO_ERR_EN
    ,
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
`endif
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard / reference model ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rd;
  bit               m_last, m_pend, m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd   = '0;
    m_last = 0;
    m_pend = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  task automatic model_step(input bit clr, input bit wren, input bit wlast,
                            input logic [WIDTH-1:0] wdata, input bit rden);
    bit full, empty;
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
    if (clr) begin
      exp_q.delete();
      m_last = 0;
      m_pend = 0;
      m_ovf  = 0;
      m_unf  = 0;
    end else begin
      m_pend = 0;
      if (rden && !empty) begin
        m_rd   = exp_q.pop_front();
        m_pend = 1;
      end
      if (wren && !full) begin
        exp_q.push_back(wdata);
        if (wlast) m_last = 1;
      end
      if (wren && full)  m_ovf = 1;
      if (rden && empty) m_unf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"}, 32'(WRCOUNT), 32'(n));
    check({tag, ".empty"}, 32'(RDEMPTY), 32'(n == 0));
    check({tag, ".full"},  32'(WRFULL),  32'(n == DEPTH));
    check({tag, ".done"},  32'(DONE),    32'(m_last && n == 0 && !m_pend));
    check({tag, ".rddata"}, RDDATA, m_rd);
`ifdef STREAM_FIFO_ERR_EN
    check({tag, ".ovf"}, 32'(OVERFLOW),  32'(m_ovf));
    check({tag, ".unf"}, 32'(UNDERFLOW), 32'(m_unf));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit clr, input bit wren, input bit wlast,
                       input logic [WIDTH-1:0] wdata, input bit rden, input string tag);
    CLR = clr; WREN = wren; WRLAST = wlast; WRDATA = wdata; RDEN = rden;
    @(posedge CLK);
    model_step(clr, wren, wlast, wdata, rden);
    @(negedge CLK);
    check_all(tag);
    CLR = 0; WREN = 0; WRLAST = 0; RDEN = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit               clr;
    bit               wren;
    bit               wlast;
    logic [WIDTH-1:0] wdata;
    bit               rden;
    int               e_cnt;
    bit               e_empty;
    bit               e_full;
    bit               e_done;
    logic [WIDTH-1:0] e_rdata;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{0, 1, 0, 32'h1111_0001, 1, 1, 0, 0, 0, 32'h0};  // write into empty + ignored read
    vecs[1]  = '{0, 1, 0, 32'h1111_0002, 0, 2, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 1, 1, 32'h1111_0003, 0, 3, 0, 0, 0, 32'h0};  // last word
    vecs[3]  = '{0, 0, 0, 32'h0,         1, 2, 0, 0, 0, 32'h1111_0001};
    vecs[4]  = '{0, 0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h1111_0002};
    vecs[5]  = '{0, 0, 0, 32'h0,         1, 0, 1, 0, 0, 32'h1111_0003};  // read still in flight
    vecs[6]  = '{0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 32'h1111_0003};
    vecs[7]  = '{0, 0, 0, 32'h0,         1, 0, 1, 0, 1, 32'h1111_0003};  // read while empty
    vecs[8]  = '{0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 32'h1111_0003};
    vecs[9]  = '{0, 1, 0, 32'h2222_0004, 0, 1, 0, 0, 0, 32'h1111_0003};  // data after last
    vecs[10] = '{0, 0, 0, 32'h0,         1, 0, 1, 0, 0, 32'h2222_0004};
    vecs[11] = '{0, 0, 0, 32'h0,         0, 0, 1, 0, 1, 32'h2222_0004};
    vecs[12] = '{0, 1, 0, 32'h3333_0000, 0, 1, 0, 0, 0, 32'h2222_0004};
    vecs[13] = '{0, 1, 0, 32'h3333_0001, 0, 2, 0, 0, 0, 32'h2222_0004};
    vecs[14] = '{0, 1, 0, 32'h3333_0002, 0, 3, 0, 0, 0, 32'h2222_0004};
    vecs[15] = '{0, 1, 0, 32'h3333_0003, 0, 4, 0, 0, 0, 32'h2222_0004};
    vecs[16] = '{0, 1, 1, 32'h3333_0004, 0, 5, 0, 0, 0, 32'h2222_0004};
    vecs[17] = '{1, 1, 0, 32'h4444_0000, 1, 0, 1, 0, 0, 32'h2222_0004};  // clear beats strobes
    vecs[18] = '{0, 0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h2222_0004};
  end

  // ---------------- test sequence ----------------
  initial begin
    RESETn = 0; CLR = 0; WREN = 0; WRLAST = 0; RDEN = 0; WRDATA = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_all("reset");
    RESETn = 1;

    foreach (vecs[i]) begin
      cycle(vecs[i].clr, vecs[i].wren, vecs[i].wlast, vecs[i].wdata, vecs[i].rden, "tbl");
      check($sformatf("tbl%0d.count", i), 32'(WRCOUNT), 32'(vecs[i].e_cnt));
      check($sformatf("tbl%0d.empty", i), 32'(RDEMPTY), 32'(vecs[i].e_empty));
      check($sformatf("tbl%0d.full", i),  32'(WRFULL),  32'(vecs[i].e_full));
      check($sformatf("tbl%0d.done", i),  32'(DONE),    32'(vecs[i].e_done));
      check($sformatf("tbl%0d.rddata", i), RDDATA, vecs[i].e_rdata);
    end

    // Fill to full, overflow, full+read drop, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 32'(i), 0, "fill");
    check("fill.full", 32'(WRFULL), 32'd1);
    check("fill.count", 32'(WRCOUNT), 32'd16);
    cycle(0, 1, 0, 32'hDEAD, 0, "ovf");
    check("ovf.count", 32'(WRCOUNT), 32'd16);
    cycle(0, 1, 0, 32'hBEEF, 1, "full_wr_rd");
    check("full_wr_rd.rddata", RDDATA, 32'd0);
    check("full_wr_rd.count", 32'(WRCOUNT), 32'd15);
    for (int i = 1; i < DEPTH; i++) begin
      cycle(0, 0, 0, '0, 1, "drain");
      check($sformatf("drain%0d.rddata", i), RDDATA, 32'(i));
    end
    check("drain.empty", 32'(RDEMPTY), 32'd1);

    // Wrap: steady concurrent traffic at half-full.
    for (int i = 0; i < DEPTH / 2; i++) cycle(0, 1, 0, 32'(100 + i), 0, "prefill");
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, $urandom, 1, "wrap");
      check("wrap.count", 32'(WRCOUNT), 32'(DEPTH / 2));
    end
    for (int i = 0; i < DEPTH / 2; i++) cycle(0, 0, 0, '0, 1, "postdrain");

    // Asynchronous reset in the middle of a write.
    for (int i = 0; i < 5; i++) cycle(0, 1, (i == 4), 32'(200 + i), 0, "prereset");
    WREN = 1; WRDATA = 32'h5555_5555;
    #2 RESETn = 0;
    #1;
    model_reset();
    check("async_rst.empty", 32'(RDEMPTY), 32'd1);
    check("async_rst.full",  32'(WRFULL),  32'd0);
    check("async_rst.done",  32'(DONE),    32'd0);
    check("async_rst.rddata", RDDATA, 32'd0);
    check("async_rst.count", 32'(WRCOUNT), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    WREN = 0;
    check_all("in_reset");
    RESETn = 1;

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      bit fill_phase;
      bit c, w, l, r;
      fill_phase = ((i / 50) % 2) == 0;
      c = ($urandom_range(0, 79) == 0);
      w = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 15) == 0);
      cycle(c, w, l, $urandom, r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
